// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_pkg
// Description : Shared definitions for the game-flow controller: FSM state
//               encodings (also decoded by the playfield logic), BCD score
//               geometry, and helpers for the score adder and the invader
//               step period.
// Revision    : 1.0 - initial release
// ============================================================================
package game_sequencer_pkg;

    // State encodings seen on the 'state' output.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_PAUSE    = 3'd2;
    localparam logic [2:0] ST_RESPAWN  = 3'd3;
    localparam logic [2:0] ST_LEVELUP  = 3'd4;
    localparam logic [2:0] ST_GAMEOVER = 3'd5;

    // Score is four BCD digits {thousands, hundreds, tens, ones}.
    localparam int          c_BCD_W      = 4;
    localparam int          c_BCD_DIGITS = 4;
    localparam logic [15:0] c_SCORE_MAX  = 16'h9990;

    // Adds pts (clamped to 9) to the tens digit and ripples the decimal
    // carry upward. A carry out of the thousands digit pins the score at
    // its maximum. The ones digit is never touched.
    function automatic logic [15:0] bcdAddTens(input logic [15:0] scoreIn,
                                               input logic [3:0]  pts);
        logic [15:0] res;
        logic [3:0]  addend;
        logic [4:0]  sum;
        logic        carry;
        res   = scoreIn;
        carry = 1'b0;
        for (int d = 1; d < c_BCD_DIGITS; d++) begin
            addend = (d == 1) ? ((pts > 4'd9) ? 4'd9 : pts) : 4'd0;
            sum    = {1'b0, res[d*c_BCD_W +: c_BCD_W]} + {1'b0, addend}
                   + {4'd0, carry};
            if (sum > 5'd9) begin
                carry = 1'b1;
                sum   = sum - 5'd10;
            end else begin
                carry = 1'b0;
            end
            res[d*c_BCD_W +: c_BCD_W] = sum[3:0];
        end
        if (carry) begin
            res = c_SCORE_MAX;
        end
        return res;
    endfunction

    // Frames per invader step for a given level, floored at minP.
    function automatic logic [7:0] stepPeriodFor(input logic [3:0] lvl,
                                                 input int initP,
                                                 input int decP,
                                                 input int minP);
        int p;
        p = initP - decP * (int'(lvl) - 1);
        if (p < minP) begin
            p = minP;
        end
        return 8'(p);
    endfunction

endpackage : game_sequencer_pkg
`default_nettype wire

// File: rtl/game_sequencer_btn_edge.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_btn_edge
// Description : Two-flop synchronizer followed by a rising-edge detector for
//               one raw, asynchronous push button.
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   btnRaw in  : raw button level
//   rise   out : high for one cycle, two cycles after the level is captured
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer_btn_edge
    import game_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btnRaw,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= btnRaw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Decoded from flops only, so the consumer sees it on the edge after
    // the level reaches r_sync.
    assign rise = r_sync & ~r_prev;

endmodule : game_sequencer_btn_edge
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow controller for the Space Invaders VGA design.
//               Derives a per-frame tick from vCount, schedules invader
//               steps and runs the attract/play/pause/respawn/level-up/
//               game-over state machine. Owns lives, level and BCD score.
//   Inputs  : clk, rst_n, vCount[9:0], BtnStart, BtnPause, player_hit,
//             inv_landed, inv_cleared, kill_valid, kill_pts[3:0]
//   Outputs : state[2:0], play_en, frame_tick, invader_step, field_reset,
//             lives[1:0], level[3:0], score[15:0] (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int LIVES_INIT  = 3,
    parameter int FRAME_LINE  = 480,
    parameter int STEP_INIT   = 32,
    parameter int STEP_DEC    = 4,
    parameter int STEP_MIN    = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  vCount,
    input  logic        BtnStart,
    input  logic        BtnPause,
    input  logic        player_hit,
    input  logic        inv_landed,
    input  logic        inv_cleared,
    input  logic        kill_valid,
    input  logic [3:0]  kill_pts,
    output logic [2:0]  state,
    output logic        play_en,
    output logic        frame_tick,
    output logic        invader_step,
    output logic        field_reset,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [15:0] score
);

    localparam logic [9:0] c_FRAME_LINE = 10'(FRAME_LINE);
    localparam logic [1:0] c_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [7:0] c_STEP_INIT  = 8'(STEP_INIT);
    localparam logic [7:0] c_HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] c_LEVEL_MAX  = 4'd15;

    logic w_startRise;
    logic w_pauseRise;

    game_sequencer_btn_edge u_startEdge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btnRaw (BtnStart),
        .rise   (w_startRise)
    );

    game_sequencer_btn_edge u_pauseEdge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btnRaw (BtnPause),
        .rise   (w_pauseRise)
    );

    // Frame event: first cycle of the trigger line. Registered into
    // frame_tick, and used directly so invader_step lands on the same edge.
    logic r_vMatchPrev;
    logic w_vMatch;
    logic w_frameEvt;

    assign w_vMatch   = (vCount == c_FRAME_LINE);
    assign w_frameEvt = w_vMatch & ~r_vMatchPrev;

    logic [7:0]  r_stepCnt;
    logic [7:0]  r_stepPeriod;
    logic [7:0]  r_holdCnt;

    logic [2:0]  w_nextState;
    logic [1:0]  w_lives;
    logic [3:0]  w_level;
    logic [3:0]  w_levelInc;
    logic [15:0] w_score;
    logic [7:0]  w_stepCnt;
    logic [7:0]  w_stepPeriod;
    logic [7:0]  w_holdCnt;
    logic        w_invStep;
    logic        w_fieldReset;

    assign w_levelInc = (level == c_LEVEL_MAX) ? c_LEVEL_MAX : level + 4'd1;

    always_comb begin
        w_nextState  = state;
        w_lives      = lives;
        w_level      = level;
        w_score      = score;
        w_stepCnt    = r_stepCnt;
        w_stepPeriod = r_stepPeriod;
        w_holdCnt    = r_holdCnt;
        w_invStep    = 1'b0;
        w_fieldReset = 1'b0;

        // Step counting only advances while playing; every other state
        // leaves it alone so a pause or respawn resumes mid-interval.
        if (state == ST_PLAY && w_frameEvt) begin
            if (r_stepCnt == r_stepPeriod - 8'd1) begin
                w_invStep = 1'b1;
                w_stepCnt = 8'd0;
            end else begin
                w_stepCnt = r_stepCnt + 8'd1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (w_startRise) begin
                    w_nextState  = ST_PLAY;
                    w_lives      = c_LIVES_INIT;
                    w_level      = 4'd1;
                    w_score      = 16'h0000;
                    w_stepCnt    = 8'd0;
                    // A fresh game starts from the level-1 period, not
                    // whatever the previous game reached.
                    w_stepPeriod = stepPeriodFor(4'd1, STEP_INIT, STEP_DEC, STEP_MIN);
                    w_fieldReset = 1'b1;
                end
            end

            ST_PLAY: begin
                // Hold timers always start from zero on entry.
                w_holdCnt = 8'd0;
                // Kills still score on the cycle the player leaves PLAY.
                if (kill_valid) begin
                    w_score = bcdAddTens(score, kill_pts);
                end
                if (inv_landed) begin
                    w_nextState = ST_GAMEOVER;
                    w_lives     = 2'd0;
                end else if (player_hit) begin
                    if (lives == 2'd1) begin
                        w_nextState = ST_GAMEOVER;
                        w_lives     = 2'd0;
                    end else begin
                        w_nextState = ST_RESPAWN;
                        w_lives     = lives - 2'd1;
                    end
                end else if (inv_cleared) begin
                    w_nextState = ST_LEVELUP;
                end else if (w_pauseRise) begin
                    w_nextState = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (w_pauseRise) begin
                    w_nextState = ST_PLAY;
                end
            end

            ST_RESPAWN, ST_LEVELUP: begin
                if (w_frameEvt) begin
                    if (r_holdCnt == c_HOLD_LAST) begin
                        w_nextState = ST_PLAY;
                        w_holdCnt   = 8'd0;
                        if (state == ST_LEVELUP) begin
                            w_level      = w_levelInc;
                            w_stepCnt    = 8'd0;
                            w_stepPeriod = stepPeriodFor(w_levelInc, STEP_INIT,
                                                         STEP_DEC, STEP_MIN);
                            w_fieldReset = 1'b1;
                        end
                    end else begin
                        w_holdCnt = r_holdCnt + 8'd1;
                    end
                end
            end

            ST_GAMEOVER: begin
                if (w_startRise) begin
                    w_nextState = ST_IDLE;
                end
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            play_en      <= 1'b0;
            frame_tick   <= 1'b0;
            invader_step <= 1'b0;
            field_reset  <= 1'b0;
            lives        <= 2'd0;
            level        <= 4'd0;
            score        <= 16'h0000;
            r_vMatchPrev <= 1'b0;
            r_stepCnt    <= 8'd0;
            r_stepPeriod <= c_STEP_INIT;
            r_holdCnt    <= 8'd0;
        end else begin
            state        <= w_nextState;
            play_en      <= (w_nextState == ST_PLAY);
            frame_tick   <= w_frameEvt;
            invader_step <= w_invStep;
            field_reset  <= w_fieldReset;
            lives        <= w_lives;
            level        <= w_level;
            score        <= w_score;
            r_vMatchPrev <= w_vMatch;
            r_stepCnt    <= w_stepCnt;
            r_stepPeriod <= w_stepPeriod;
            r_holdCnt    <= w_holdCnt;
        end
    end

endmodule : game_sequencer
`default_nettype wire
